// File: rtl/game_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// game_countdown_timer_if
// Groups the round-timer control inputs and display/status outputs.
//   master : drives tick/start/pause/finish, observes the timer outputs
//   slave  : the timer itself
// Signals:
//   tick      1-cycle pulse per second from the 1 Hz divider
//   start     level, starts/restarts a round
//   pause     level, holds the count while high
//   finish    level, player reached the exit
//   rem_tens  BCD tens of seconds remaining
//   rem_ones  BCD ones of seconds remaining
//   elapsed   binary seconds elapsed this round
//   hex1/hex0 active-low {g,f,e,d,c,b,a} patterns for rem_tens/rem_ones
//   running, warning, time_up, expired, finished  status flags
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface game_countdown_timer_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic       finish;
  logic [3:0] rem_tens;
  logic [3:0] rem_ones;
  logic [6:0] elapsed;
  logic [6:0] hex1;
  logic [6:0] hex0;
  logic       running;
  logic       warning;
  logic       time_up;
  logic       expired;
  logic       finished;

  modport master (
    output tick, start, pause, finish,
    input  rem_tens, rem_ones, elapsed, hex1, hex0,
    input  running, warning, time_up, expired, finished
  );

  modport slave (
    input  tick, start, pause, finish,
    output rem_tens, rem_ones, elapsed, hex1, hex0,
    output running, warning, time_up, expired, finished
  );
endinterface

// File: rtl/game_countdown_timer.sv
// ---------------------------------------------------------------------------
// game_countdown_timer
// Maze-game round timer. Each tick decrements a BCD seconds-remaining count
// and increments a binary elapsed count; a control FSM handles start, pause,
// finish and expiry. Two active-low seven-segment patterns drive the HEX
// displays.
// Parameters:
//   TIME_LIMIT      round length in seconds, 1..99
//   WARN_THRESHOLD  warning asserts in RUN when remaining <= this value
// Ports:
//   clock   system clock
//   resetn  synchronous, active-low reset
//   tmr     slave side of game_countdown_timer_if (controls in, status out)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module game_countdown_timer #(
  parameter int TIME_LIMIT     = 99,
  parameter int WARN_THRESHOLD = 10
) (
  input  logic                   clock,
  input  logic                   resetn,
  game_countdown_timer_if.slave  tmr
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    PAUSE    = 3'd2,
    EXPIRED  = 3'd3,
    FINISHED = 3'd4
  } state_t;

  localparam logic [3:0] LIMIT_TENS = 4'(TIME_LIMIT / 10);
  localparam logic [3:0] LIMIT_ONES = 4'(TIME_LIMIT % 10);
  localparam logic [6:0] WARN_LEVEL = 7'(WARN_THRESHOLD);
  localparam logic [6:0] ELAPSED_MAX = 7'd99;

  state_t     state;
  logic [3:0] rem_tens_q;
  logic [3:0] rem_ones_q;
  logic [6:0] elapsed_q;
  logic       time_up_q;

  // Remaining time as a plain binary value, used only for the warning compare.
  logic [6:0] rem_bin;
  logic       last_second;
  logic       rem_zero;

  assign rem_bin     = {3'b000, rem_tens_q} * 7'd10 + {3'b000, rem_ones_q};
  assign last_second = (rem_tens_q == 4'd0) && (rem_ones_q == 4'd1);
  assign rem_zero    = (rem_tens_q == 4'd0) && (rem_ones_q == 4'd0);

  // Active-low {g,f,e,d,c,b,a}; codes 10..15 blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    // NOTE: every path assigns seg (default first), so no latch is inferred.
    seg = 7'b1111111;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      state      <= IDLE;
      rem_tens_q <= LIMIT_TENS;
      rem_ones_q <= LIMIT_ONES;
      elapsed_q  <= 7'd0;
      time_up_q  <= 1'b0;
    end else begin
      time_up_q <= 1'b0;
      case (state)
        IDLE: begin
          // A tick arriving with start is deliberately dropped.
          if (tmr.start) begin
            rem_tens_q <= LIMIT_TENS;
            rem_ones_q <= LIMIT_ONES;
            elapsed_q  <= 7'd0;
            state      <= RUN;
          end
        end

        RUN: begin
          if (tmr.finish) begin
            state <= FINISHED;
          end else if (tmr.pause) begin
            state <= PAUSE;
          end else if (tmr.tick && !rem_zero) begin
            // BCD decrement with borrow from the tens digit.
            if (rem_ones_q != 4'd0) begin
              rem_ones_q <= rem_ones_q - 4'd1;
            end else begin
              rem_ones_q <= 4'd9;
              rem_tens_q <= rem_tens_q - 4'd1;
            end
            if (elapsed_q != ELAPSED_MAX) begin
              elapsed_q <= elapsed_q + 7'd1;
            end
            if (last_second) begin
              state     <= EXPIRED;
              time_up_q <= 1'b1;
            end
          end
        end

        PAUSE: begin
          if (tmr.finish) begin
            state <= FINISHED;
          end else if (!tmr.pause) begin
            state <= RUN;
          end
        end

        EXPIRED, FINISHED: begin
          // Counters freeze; a held start restarts immediately.
          if (tmr.start) begin
            rem_tens_q <= LIMIT_TENS;
            rem_ones_q <= LIMIT_ONES;
            elapsed_q  <= 7'd0;
            state      <= RUN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign tmr.rem_tens = rem_tens_q;
  assign tmr.rem_ones = rem_ones_q;
  assign tmr.elapsed  = elapsed_q;
  assign tmr.hex1     = seg7(rem_tens_q);
  assign tmr.hex0     = seg7(rem_ones_q);
  assign tmr.running  = (state == RUN);
  assign tmr.expired  = (state == EXPIRED);
  assign tmr.finished = (state == FINISHED);
  assign tmr.warning  = (state == RUN) && (rem_bin <= WARN_LEVEL);
  assign tmr.time_up  = time_up_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
`timescale 1ns/1ps
module tb_game_countdown_timer;

  localparam int LIMIT_A = 12;
  localparam int LIMIT_B = 99;
  localparam int WARN    = 10;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  always #5 clock = ~clock;

  game_countdown_timer_if if12 ();
  game_countdown_timer_if if99 ();

  game_countdown_timer #(.TIME_LIMIT(LIMIT_A), .WARN_THRESHOLD(WARN)) dut12 (
    .clock  (clock),
    .resetn (resetn),
    .tmr    (if12)
  );

  game_countdown_timer #(.TIME_LIMIT(LIMIT_B), .WARN_THRESHOLD(WARN)) dut99 (
    .clock  (clock),
    .resetn (resetn),
    .tmr    (if99)
  );

  // Reference seven-segment table, active-low {g..a}.
  logic [6:0] seg_ref [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit start;
    bit pause;
    bit finish;
    bit tick;
    int rem;
    int el;
    bit run;
    bit warn;
    bit tu;
    bit exp_st;
    bit fin;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit s, input bit p, input bit f, input bit t,
                     input int rem, input int el, input bit run, input bit warn,
                     input bit tu, input bit ex, input bit fin);
    vec_t v;
    v.start = s; v.pause = p; v.finish = f; v.tick = t;
    v.rem = rem; v.el = el; v.run = run; v.warn = warn;
    v.tu = tu; v.exp_st = ex; v.fin = fin;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive12(input bit s, input bit p, input bit f, input bit t);
    if12.start = s; if12.pause = p; if12.finish = f; if12.tick = t;
  endtask

  task automatic check12(input string tag, input int rem, input int el,
                         input bit run, input bit warn, input bit tu,
                         input bit ex, input bit fin);
    check({tag, ".tens"},     int'(if12.rem_tens), rem / 10);
    check({tag, ".ones"},     int'(if12.rem_ones), rem % 10);
    check({tag, ".elapsed"},  int'(if12.elapsed),  el);
    check({tag, ".hex1"},     int'(if12.hex1),     int'(seg_ref[rem / 10]));
    check({tag, ".hex0"},     int'(if12.hex0),     int'(seg_ref[rem % 10]));
    check({tag, ".running"},  int'(if12.running),  int'(run));
    check({tag, ".warning"},  int'(if12.warning),  int'(warn));
    check({tag, ".time_up"},  int'(if12.time_up),  int'(tu));
    check({tag, ".expired"},  int'(if12.expired),  int'(ex));
    check({tag, ".finished"}, int'(if12.finished), int'(fin));
  endtask

  // Behavioural reference: round phase plus integer seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3, M_FIN = 4;
  int m_mode;
  int m_rem;
  int m_el;
  bit m_tu;

  task automatic model_step(input bit s, input bit p, input bit f, input bit t);
    m_tu = 1'b0;
    case (m_mode)
      M_IDLE: if (s) begin m_mode = M_RUN; m_rem = LIMIT_A; m_el = 0; end
      M_RUN: begin
        if (f) m_mode = M_FIN;
        else if (p) m_mode = M_PAUSE;
        else if (t) begin
          m_rem = m_rem - 1;
          m_el  = (m_el < 99) ? m_el + 1 : 99;
          if (m_rem == 0) begin m_mode = M_EXP; m_tu = 1'b1; end
        end
      end
      M_PAUSE: begin
        if (f) m_mode = M_FIN;
        else if (!p) m_mode = M_RUN;
      end
      default: if (s) begin m_mode = M_RUN; m_rem = LIMIT_A; m_el = 0; end
    endcase
  endtask

  initial begin
    drive12(0, 0, 0, 0);
    if99.start = 0; if99.pause = 0; if99.finish = 0; if99.tick = 0;

    // ---------------- directed vector table (TIME_LIMIT = 12) -------------
    add(1,0,0,0, 12, 0, 1,0,0,0,0);   // start -> RUN, 12
    add(0,0,0,1, 11, 1, 1,0,0,0,0);
    add(0,0,0,1, 10, 2, 1,1,0,0,0);   // at threshold
    add(0,0,0,1,  9, 3, 1,1,0,0,0);   // borrow 10 -> 09
    add(0,1,0,1,  9, 3, 0,0,0,0,0);   // pause wins over tick
    add(0,1,0,1,  9, 3, 0,0,0,0,0);
    add(0,1,0,1,  9, 3, 0,0,0,0,0);
    add(0,0,0,0,  9, 3, 1,1,0,0,0);   // back to RUN
    add(0,0,0,1,  8, 4, 1,1,0,0,0);
    add(0,0,1,1,  8, 4, 0,0,0,0,1);   // finish wins over tick
    add(0,0,0,1,  8, 4, 0,0,0,0,1);   // frozen
    add(1,0,0,0, 12, 0, 1,0,0,0,0);   // restart from FINISHED
    add(1,0,0,1, 11, 1, 1,0,0,0,0);   // start ignored in RUN
    for (int r = 10; r >= 1; r--) add(0,0,0,1, r, LIMIT_A - r, 1, r <= WARN, 0,0,0);
    add(0,0,0,1,  0,12, 0,0,1,1,0);   // expiry
    add(0,0,0,1,  0,12, 0,0,0,1,0);   // time_up single cycle
    add(0,0,0,1,  0,12, 0,0,0,1,0);
    add(1,0,0,0, 12, 0, 1,0,0,0,0);   // restart from EXPIRED
    add(0,0,0,1, 11, 1, 1,0,0,0,0);
    add(0,0,0,1, 10, 2, 1,1,0,0,0);

    // ---------------- reset ----------------
    repeat (3) cyc();
    check12("reset", 12, 0, 0,0,0,0,0);
    resetn = 1'b1;
    cyc();
    check12("idle", 12, 0, 0,0,0,0,0);

    foreach (vecs[i]) begin
      drive12(vecs[i].start, vecs[i].pause, vecs[i].finish, vecs[i].tick);
      cyc();
      check12($sformatf("vec%0d", i), vecs[i].rem, vecs[i].el, vecs[i].run,
              vecs[i].warn, vecs[i].tu, vecs[i].exp_st, vecs[i].fin);
    end

    // ---------------- mid-round reset ----------------
    drive12(0, 0, 0, 1);
    resetn = 1'b0;
    cyc();
    check12("midreset", 12, 0, 0,0,0,0,0);
    resetn = 1'b1;
    drive12(0, 0, 0, 1);               // tick alone in IDLE does nothing
    cyc();
    check12("idle_tick", 12, 0, 0,0,0,0,0);
    drive12(1, 0, 0, 1);               // tick with start is ignored
    cyc();
    check12("start_tick", 12, 0, 1,0,0,0,0);

    // ---------------- randomized run vs reference model ----------------
    m_mode = M_RUN; m_rem = LIMIT_A; m_el = 0; m_tu = 1'b0;
    for (int n = 0; n < 600; n++) begin
      bit s, p, f, t;
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 24) == 0);
      t = ($urandom_range(0, 1) == 1);
      drive12(s, p, f, t);
      cyc();
      model_step(s, p, f, t);
      check12($sformatf("rnd%0d", n), m_rem, m_el, m_mode == M_RUN,
              (m_mode == M_RUN) && (m_rem <= WARN), m_tu,
              m_mode == M_EXP, m_mode == M_FIN);
      check($sformatf("rnd%0d.sum", n),
            int'(if12.elapsed) + 10 * int'(if12.rem_tens) + int'(if12.rem_ones), LIMIT_A);
    end
    drive12(0, 0, 0, 0);

    // ---------------- display sweep (TIME_LIMIT = 99) ----------------
    if99.start = 1'b1;
    cyc();
    if99.start = 1'b0;
    check("sweep.start.hex1", int'(if99.hex1), int'(seg_ref[9]));
    check("sweep.start.hex0", int'(if99.hex0), int'(seg_ref[9]));
    check("sweep.start.running", int'(if99.running), 1);
    for (int k = 1; k <= LIMIT_B; k++) begin
      int rem;
      rem = LIMIT_B - k;
      if99.tick = 1'b1;
      cyc();
      check($sformatf("sweep%0d.tens", k), int'(if99.rem_tens), rem / 10);
      check($sformatf("sweep%0d.ones", k), int'(if99.rem_ones), rem % 10);
      check($sformatf("sweep%0d.hex1", k), int'(if99.hex1), int'(seg_ref[rem / 10]));
      check($sformatf("sweep%0d.hex0", k), int'(if99.hex0), int'(seg_ref[rem % 10]));
      check($sformatf("sweep%0d.sum", k),
            int'(if99.elapsed) + 10 * int'(if99.rem_tens) + int'(if99.rem_ones), LIMIT_B);
    end
    check("sweep.end.time_up", int'(if99.time_up), 1);
    check("sweep.end.expired", int'(if99.expired), 1);
    cyc();
    if99.tick = 1'b0;
    check("sweep.hold.time_up", int'(if99.time_up), 0);
    check("sweep.hold.ones", int'(if99.rem_ones), 0);
    check("sweep.hold.elapsed", int'(if99.elapsed), 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_countdown_timer.md
# game_countdown_timer

Round timer for the maze game, downstream of the 1 Hz divider. Each one-cycle `tick` (asserted when the divider counter reaches zero) decrements a BCD seconds-remaining count and increments a binary elapsed count. A control FSM handles start, pause, finish (player reached exit) and expiry. Two active-low seven-segment patterns drive the HEX displays.

## Interface
- `TIME_LIMIT`, default 99: round length in seconds; legal range 1..99.
- `WARN_THRESHOLD`, default 10: `warning` asserts when remaining ≤ this value while in RUN.
- `clock`  in  1  system clock (50 MHz).
- `resetn`  in  1  synchronous, active-low reset.
- `tick`  in  1  one-cycle pulse, one per second, from the 1 Hz divider.
- `start`  in  1  level; starts or restarts a round (see FSM).
- `pause`  in  1  level; holds the count while high.
- `finish`  in  1  level; player reached the exit and the count freezes.
- `rem_tens`  out  4  BCD tens of seconds remaining.
- `rem_ones`  out  4  BCD ones of seconds remaining.
- `elapsed`  out  7  binary seconds elapsed this round.
- `hex1`  out  7  active-low segments {g,f,e,d,c,b,a} for `rem_tens`.
- `hex0`  out  7  active-low segments for `rem_ones`.
- `running`  out  1  high in RUN.
- `warning`  out  1  high in RUN when remaining ≤ `WARN_THRESHOLD`.
- `time_up`  out  1  one-cycle pulse on the cycle EXPIRED is entered.
- `expired`  out  1  high in EXPIRED.
- `finished`  out  1  high in FINISHED.

## Operation
- **States:** IDLE, RUN, PAUSE, EXPIRED, FINISHED (registered state, 3 bits).
- **Reset (`resetn` = 0 at a clock edge):**
  - state ← IDLE; remaining ← `TIME_LIMIT` in BCD; `elapsed` ← 0.
  - `running`, `warning`, `time_up`, `expired`, `finished` ← 0.
  - Reset mid-round discards all progress.
- **IDLE:** `start` = 1 → RUN. A `tick` in the same cycle is ignored.
- **RUN:** evaluate in this priority order.
  - `finish` = 1 → FINISHED, with no decrement even if `tick` = 1.
  - Otherwise `pause` = 1 → PAUSE, with no decrement.
  - Otherwise `tick` = 1 → decrement.
- **Decrement:**
  - If ones ≠ 0, ones − 1.
  - Else ones ← 9 and tens − 1.
  - `elapsed` + 1, saturating at 99.
  - If remaining was 01, it becomes 00, state → EXPIRED, and `time_up` pulses for one cycle.
- **PAUSE:**
  - `finish` = 1 → FINISHED.
  - Else `pause` = 0 → RUN.
  - `tick` is ignored throughout.
- **EXPIRED / FINISHED:**
  - Counters hold.
  - `start` = 1 → reload remaining to `TIME_LIMIT`, `elapsed` ← 0, state → RUN.
  - `start` held high across expiry restarts on the next cycle; this is intended for level-type pushbuttons.
- **`start` in RUN or PAUSE:** ignored. Restart only from IDLE, EXPIRED or FINISHED.
- **Invariants:**
  - remaining is never below 00 and never wraps to 99.
  - `elapsed` + remaining = `TIME_LIMIT` at all times within a round.
- **Seven-segment decode, active-low {g..a}:**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 decode to blank, 1111111.

## Timing
- Counters, state and flags are registered. `tick` sampled at edge N is visible on `rem_*`/`elapsed` after edge N (1-cycle latency).
- `hex1`/`hex0` are combinational from the registered BCD digits, so they change in the same cycle as `rem_*`.
- `running`, `expired`, `finished` are decoded from the state register (glitch-free, same cycle as state).
- `warning` updates in the same cycle as remaining.
- `time_up` is high for exactly the one cycle following the expiring edge.
- `tick` is assumed ≤ 1 cycle wide. Back-to-back ticks (test only) decrement once per cycle.

## Test plan
- **Reset and start:** hold `resetn` = 0 then release; set `TIME_LIMIT` = 12 and pulse `start`. Expect `rem_tens`/`rem_ones` = 1/2, `hex1` = 1111001, `hex0` = 0100100, `elapsed` = 0, `running` = 1 one cycle after `start`.
- **Borrow:** at remaining 10, send one `tick`. Expect tens/ones = 0/9, `elapsed` = 3, `warning` = 1 (`WARN_THRESHOLD` = 10).
- **Expiry:** with remaining 01, send a `tick`. Expect remaining 00, `time_up` high for one cycle, `expired` = 1. Further ticks leave remaining at 00 and `elapsed` at 12.
- **Pause and finish priority:** in RUN, raise `pause` and send 3 ticks; remaining is unchanged. Drop `pause`; the next tick decrements. Assert `finish` and `tick` together; expect FINISHED with no decrement.
- **Restart and mid-round reset:** from FINISHED, pulse `start`; expect remaining = 12, `elapsed` = 0, RUN. Later assert `resetn` = 0 mid-round; expect IDLE, remaining = 12, all flags 0.
- **Display sweep:** count `TIME_LIMIT` = 99 down to 00 with ticks. Check each `hex0`/`hex1` pattern against the table, and check `elapsed` + remaining = 99 at every step.
